// File: rtl/uart_defs.sv
// uart_defs: shared UART types -- mode/config encodings and the flow-arbiter state.
package uart_defs;
  typedef enum logic [1:0] {
    FULLDUPLEX = 2'd0,
    HALFDUPLEX = 2'd1,
    SIMPLEX    = 2'd2
  } uart_mode_t;

  typedef struct packed {
    uart_mode_t mode;
    logic       master;
  } Config_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TX    = 2'd1,
    RX    = 2'd2,
    GUARD = 2'd3
  } FlowState_t;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: N-flop synchroniser for an asynchronous input, resetting to 1 (idle-high lines).
module uart_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [N-1:0] r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '1;
    else r <= {r[N-2:0], d};
  assign q = r[N-1];
endmodule

// File: rtl/uart_flow_arbiter.sv
// uart_flow_arbiter: RTS/CTS flow control with watermark hysteresis, frame-safe TX gating
// and half-duplex direction arbitration with a bus-turnaround guard.
module uart_flow_arbiter
  import uart_defs::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int GUARD_W     = 8,
  parameter int SYNC_STAGES = 2,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               tck,
  input  logic               rst_n,
  input  Config_t            uart_config_i,
  input  logic               cts_n_i,
  output logic               rts_n_o,
  input  logic               tx_req_i,
  input  logic               tx_busy_i,
  output logic               tx_grant_o,
  input  logic               rx_active_i,
  input  logic [LVL_W-1:0]   rx_level_i,
  input  logic [LVL_W-1:0]   rx_hi_wm_i,
  input  logic [LVL_W-1:0]   rx_lo_wm_i,
  input  logic [GUARD_W-1:0] guard_cycles_i,
  output logic               tx_enable_o,
  output logic               rx_enable_o,
  output logic [1:0]         state_o
);
  FlowState_t         st_q, st_d;
  logic [GUARD_W-1:0] cnt_q, cnt_d;
  Config_t            cfg_q;
  logic               rx_block, rxb_d, cts_sync, hd, sx, done, fd_grant, guard_zero;

  uart_sync #(.N(SYNC_STAGES)) u_cts_sync (
    .clk  (tck),
    .rst_n(rst_n),
    .d    (cts_n_i),
    .q    (cts_sync)
  );

  always_comb begin
    hd         = uart_config_i.mode == HALFDUPLEX;
    sx         = uart_config_i.mode == SIMPLEX;
    fd_grant   = tx_req_i & ~cts_sync & ~tx_busy_i;
    guard_zero = guard_cycles_i == '0;
    // set wins over clear, so an inverted watermark pair acts as a plain threshold
    rxb_d = (rx_level_i >= rx_hi_wm_i || rx_level_i == LVL_W'(FIFO_DEPTH)) ? 1'b1 :
            (rx_level_i <= rx_lo_wm_i) ? 1'b0 : rx_block;
    done  = (st_q == TX && !tx_busy_i && !tx_req_i) || (st_q == RX && !rx_active_i);
    st_d  = st_q;
    cnt_d = cnt_q;
    if (uart_config_i != cfg_q || !hd) begin
      st_d  = IDLE;
      cnt_d = '0;
    end else if (done) begin
      st_d  = guard_zero ? IDLE : GUARD;
      cnt_d = guard_zero ? '0 : guard_cycles_i - GUARD_W'(1);
    end else if (st_q == IDLE) begin
      st_d = rx_active_i ? RX : fd_grant | (tx_req_i & ~cts_sync) ? TX : IDLE;
    end else if (st_q == GUARD) begin
      st_d  = cnt_q == '0 ? IDLE : GUARD;
      cnt_d = cnt_q == '0 ? '0 : cnt_q - GUARD_W'(1);
    end
  end

  always_ff @(posedge tck or negedge rst_n)
    if (!rst_n) begin
      st_q        <= IDLE;
      cnt_q       <= '0;
      cfg_q       <= '0;
      rx_block    <= 1'b0;
      rts_n_o     <= 1'b1;
      tx_grant_o  <= 1'b0;
      tx_enable_o <= 1'b0;
      rx_enable_o <= 1'b0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      cfg_q       <= uart_config_i;
      rx_block    <= rxb_d;
      tx_enable_o <= hd ? st_d == TX : sx ? uart_config_i.master : 1'b1;
      rx_enable_o <= hd ? (st_d == IDLE || st_d == RX) : sx ? ~uart_config_i.master : 1'b1;
      rts_n_o     <= hd ? ((st_d == IDLE || st_d == RX) ? rxb_d : 1'b1) :
                     (sx && uart_config_i.master) ? 1'b1 : rxb_d;
      tx_grant_o  <= hd ? (st_d == TX && !tx_busy_i && !cts_sync) :
                     (sx && !uart_config_i.master) ? 1'b0 : fd_grant;
    end

  assign state_o = st_q;
endmodule

// File: doc/uart_flow_arbiter.md
Name: uart_flow_arbiter

Overview:
- Parametrised successor to the UART RTS/CTS flow-control block.
- Sits between the UART pins (rts_n_o/cts_n_i), the TX serializer and the RX FIFO.
- Adds several functions:
  - CTS input synchronisation.
  - RX-FIFO watermark hysteresis driving RTS.
  - Frame-boundary TX gating, so a frame is never cut mid-way.
  - Half-duplex direction arbitration with a programmable bus-turnaround guard.
  - Explicit simplex master/slave handling.

Parameters:
- FIFO_DEPTH, 16: RX FIFO depth; sets LVL_W = $clog2(FIFO_DEPTH+1).
- GUARD_W, 8: width of the turnaround guard counter.
- SYNC_STAGES, 2: flops in the cts_n_i synchroniser (legal range >= 2).

Ports:
- tck  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- uart_config_i  in  Config_t  mode (FULLDUPLEX/HALFDUPLEX/SIMPLEX) and master bit.
- cts_n_i  in  1  remote clear-to-send, async, low = remote may receive.
- rts_n_o  out  1  local ready-to-receive, low = we accept data.
- tx_req_i  in  1  TX has a frame pending.
- tx_busy_i  in  1  TX frame in progress (start bit through stop bit).
- tx_grant_o  out  1  TX may start a new frame this cycle.
- rx_active_i  in  1  RX start bit detected / frame in progress.
- rx_level_i  in  LVL_W  current RX FIFO fill.
- rx_hi_wm_i  in  LVL_W  level at which RTS is deasserted.
- rx_lo_wm_i  in  LVL_W  level at which RTS is reasserted.
- guard_cycles_i  in  GUARD_W  turnaround guard length in tck cycles.
- tx_enable_o  out  1  TX path enable.
- rx_enable_o  out  1  RX path enable.
- state_o  out  2  current FlowState_t, for debug/status.

Behaviour:

Reset values:
- rts_n_o=1, tx_grant_o=0, tx_enable_o=0, rx_enable_o=0.
- state IDLE, guard counter 0, all sync flops 1, rx_block=0.

Output timing:
- All outputs are registered and decoded from next state.
- They are valid in the same cycle as state_q.
- cts_n_i reaches the logic after SYNC_STAGES cycles; tx_grant_o reacts one further cycle later.

Watermark hysteresis (rx_block register):
- Set when rx_level_i >= rx_hi_wm_i.
- Cleared when rx_level_i <= rx_lo_wm_i.
- Set has priority when both hold, so hi_wm <= lo_wm degenerates to a pure threshold.
- rx_level_i == FIFO_DEPTH always sets rx_block.

FlowState_t states: IDLE, TX, RX, GUARD.

FULLDUPLEX:
- FSM held in IDLE.
- tx_enable_o=1 and rx_enable_o=1.
- rts_n_o = rx_block.
- tx_grant_o = tx_req_i & !cts_sync & !tx_busy_i.
- CTS deasserting mid-frame: grant drops and the current frame completes; no abort.

HALFDUPLEX transitions:
- IDLE -> RX when rx_active_i. RX has priority over a simultaneous tx_req_i.
- IDLE -> TX when tx_req_i & !cts_sync & !rx_active_i.
- TX -> GUARD when !tx_busy_i & !tx_req_i. Pending back-to-back frames stay in TX.
- RX -> GUARD when !rx_active_i.
- On GUARD entry the counter loads guard_cycles_i-1. GUARD -> IDLE when the counter == 0.
- guard_cycles_i == 0: GUARD is skipped and the FSM goes directly to IDLE.

HALFDUPLEX outputs:
- tx_enable_o = 1 only in TX.
- rx_enable_o = 1 in IDLE and RX.
- rts_n_o = rx_block in IDLE and RX; forced 1 in TX and GUARD.
- tx_grant_o = 1 only in TX with !tx_busy_i & !cts_sync.
- cts_sync high while in TX: no new grant; the FSM stays in TX while tx_req_i holds.

SIMPLEX:
- FSM held in IDLE.
- master=1: tx_enable_o=1, rx_enable_o=0, rts_n_o=1, grant as in full duplex.
- master=0: tx_enable_o=0, rx_enable_o=1, tx_grant_o=0, rts_n_o=rx_block.

Config change:
- A change in mode or master, compared with a registered copy, forces the FSM to IDLE next cycle and clears the guard counter.
- rx_block is kept.

Reset mid-operation:
- All state returns immediately to reset values.

Decomposition:
- uart_defs gains FlowState_t (2-bit enum IDLE=0, TX=1, RX=2, GUARD=3). Config_t and the mode encodings stay there.
- One sub-module: uart_sync (parametrised N-flop synchroniser with reset value 1), used for cts_n_i.

Test Plan:
1. FULLDUPLEX, cts_n_i=0, tx_req_i=1 pulse -> tx_grant_o=1 exactly SYNC_STAGES+1 cycles later. Raise cts_n_i with tx_busy_i=1 -> busy frame unaffected, no further grant.
2. hi_wm=12, lo_wm=4, level ramps 0->13->3 -> rts_n_o rises at the cycle after level=12 and falls the cycle after level=4. Level 8 on the way down keeps rts_n_o=1.
3. HALFDUPLEX, rx_active_i and tx_req_i rise in the same cycle -> state RX, rts_n_o=rx_block, tx_grant_o=0. rx_active_i falls with guard=5 -> GUARD for 5 cycles, then IDLE, then TX.
4. HALFDUPLEX TX with guard_cycles_i=0 -> TX->IDLE directly. rts_n_o=1 throughout TX.
5. SIMPLEX master=0, tx_req_i=1, cts_n_i=0 -> tx_grant_o stays 0, rx_enable_o=1. Toggle master mid-TX in HALFDUPLEX -> state IDLE next cycle.
6. Assert rst_n=0 mid-GUARD -> all outputs at reset values asynchronously, state_o=IDLE.
